riscv_datamem_arbiter: RTL and testbench
========================================

# riscv_datamem_arbiter

Two-port arbiter and sequencer in front of the single-ported data memory. Accepts word-sized load/store requests from port 0 (core load/store unit) and port 1 (debug/DMA port), selects one per transaction, drives the memory's address/read-enable/write-enable/write-data inputs for exactly one cycle, and returns registered read data, an acknowledge and error status to the winning requester. It also blocks writes to misaligned or out-of-range addresses before they reach the memory.

## Interface
- `IDX_W`, default `` `DATAMEM_WIDTH ``: memory index width; valid byte addresses are below 2^(IDX_W+3).
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `p0_req_i`, `p1_req_i` in 1: request valid; held high with stable payload until the matching ack.
- `p0_we_i`, `p1_we_i` in 1: 1 = store, 0 = load.
- `p0_addr_i`, `p1_addr_i` in 64: byte address.
- `p0_wdata_i`, `p1_wdata_i` in 64: store data.
- `p0_ack_o`, `p1_ack_o` out 1: one-cycle completion pulse.
- `rdata_o` out 64: load data; valid while an ack is high, otherwise 0.
- `err_o` out 2: bit0 = misaligned, bit1 = invalid address; valid while an ack is high.
- `mem_addr_o` out 64, `mem_re_o` out 1, `mem_we_o` out 1, `mem_wdata_o` out 64: memory drive.
- `mem_rdata_i` in 64: memory read data (combinational from `mem_addr_o`).

## Operation
- FSM states: IDLE, ACCESS, DONE. Reset state is IDLE. `owner` (1 bit) and `last` (1 bit) reset to 0. Latched `addr`, `we`, `wdata`, `rdata` and `err` registers reset to 0.
- **IDLE:** if any request is high, pick a winner, latch its `addr`, `we` and `wdata`, set `owner`, and go to ACCESS. Otherwise stay in IDLE.
- **Pre-check on the latched address:**
  - `mis = addr[2:0] != 0`
  - `inv = addr[63:IDX_W+3] != 0`
- **ACCESS:**
  - `mem_addr_o = addr`
  - `mem_re_o = !we & !mis & !inv`
  - `mem_we_o = we & !mis & !inv`
  - `mem_wdata_o = wdata`
  - At the edge, capture `rdata` (equal to `mem_rdata_i` when `mem_re_o`, else 0) and `err = {inv, mis}`. Set `last = owner`. Go to DONE.
- **DONE:** assert ack for `owner`; drive `rdata_o` and `err_o` from the captured registers. Go to IDLE unconditionally. Requests are ignored in DONE.
- Outside ACCESS: `mem_re_o = mem_we_o = 0`, and `mem_addr_o` and `mem_wdata_o` are 0.
- A store with an error does not modify memory and still acks, with `rdata_o = 0`.
- Simultaneous requests follow the selection rule under Configuration. The losing requester stays pending and is served in the next transaction.
- **Reset mid-transaction:** asserting `rst` forces IDLE immediately, so `mem_we_o` falls in the same cycle and no write commits. No ack is issued, the pending request is dropped, and the requester re-arbitrates after reset releases.

## Timing
- Fixed latency: request sampled at edge N (state IDLE); ACCESS during cycle N+1; ack high during cycle N+2; IDLE again in cycle N+3.
- A store commits in memory at the edge ending the ACCESS cycle.
- Requester rule: after seeing ack, deassert the request or present a new payload for the following cycle. A held request is treated as a new transaction.
- Peak throughput: one transaction per 3 cycles.
- Reset values of all outputs: acks 0, `rdata_o = 0`, `err_o = 0`, `mem_*_o = 0`.

## Configuration
- `DATAMEM_ARB_RR_EN` defined: round-robin. On simultaneous requests, the port not equal to `last` wins. A single request always wins.
- `DATAMEM_ARB_RR_EN` undefined: fixed priority, port 0 always wins. The `last` register is absent and port 1 can starve.

## Test plan
- Single load, port 0, memory word 1 = 64'hDEADBEEF_00000001: `p0_addr_i = 8` at edge N -> `mem_re_o` high in N+1 with `mem_addr_o = 8`; `p0_ack_o` high in N+2 with `rdata_o = 64'hDEADBEEF_00000001` and `err_o = 0`.
- Store then load, port 1: store 64'h1234 to address 16, then load from 16 -> `mem_we_o` pulses for exactly one cycle; the load returns 64'h1234; `p0_ack_o` stays 0 throughout.
- Simultaneous requests, both ports loading, each held for 4 transactions -> with RR: grant order p0, p1, p0, p1. Without RR: p0 for all 4, with p1 served only after p0 drops its request.
- Error store to address 12 with data 64'hFF -> `mem_we_o` stays 0; ack with `err_o = 2'b01`; a later load from address 8 returns its original value. Load from address 2^(IDX_W+3) -> `err_o = 2'b10`, `rdata_o = 0`.
- Reset during ACCESS of a store to address 24 -> `mem_we_o` drops in the same cycle; no ack; memory word 3 unchanged; after reset releases, the still-held request completes normally 3 cycles later.

Source files
------------

// File: rtl/riscv_datamem_arbiter.sv
// Two-port load/store arbiter and one-cycle sequencer for the single-ported data memory.
// Define DATAMEM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
`ifndef DATAMEM_WIDTH
`define DATAMEM_WIDTH 10
`endif

module riscv_datamem_arbiter #(
  parameter int IDX_W = `DATAMEM_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req_i,
  input  logic        p0_we_i,
  input  logic [63:0] p0_addr_i,
  input  logic [63:0] p0_wdata_i,
  input  logic        p1_req_i,
  input  logic        p1_we_i,
  input  logic [63:0] p1_addr_i,
  input  logic [63:0] p1_wdata_i,
  output logic        p0_ack_o,
  output logic        p1_ack_o,
  output logic [63:0] rdata_o,
  output logic [1:0]  err_o,
  output logic [63:0] mem_addr_o,
  output logic        mem_re_o,
  output logic        mem_we_o,
  output logic [63:0] mem_wdata_o,
  input  logic [63:0] mem_rdata_i,
  output logic [1:0]  dbg_state_o
);

  // Handshake: a port holds req with a stable payload until its ack pulse;
  // ack lasts exactly one cycle and rdata_o/err_o are only meaningful then.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic [63:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] rdata_q, rdata_d;
  logic [1:0]  err_q, err_d;
  logic        win;
  logic        mis;
  logic        inv;
`ifdef DATAMEM_ARB_RR_EN
  logic        last_q, last_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= '0;
`ifdef DATAMEM_ARB_RR_EN
      last_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef DATAMEM_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
`ifdef DATAMEM_ARB_RR_EN
    last_d      = last_q;
    win         = (p0_req_i && p1_req_i) ? ~last_q : p1_req_i;
`else
    win         = ~p0_req_i;
`endif
    mis         = (addr_q[2:0] != 3'd0);
    inv         = ((addr_q >> (IDX_W + 3)) != 64'd0);
    mem_addr_o  = '0;
    mem_re_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_wdata_o = '0;
    p0_ack_o    = 1'b0;
    p1_ack_o    = 1'b0;
    rdata_o     = '0;
    err_o       = '0;

    case (state_q)
      IDLE: begin
        if (p0_req_i || p1_req_i) begin
          owner_d = win;
          addr_d  = win ? p1_addr_i  : p0_addr_i;
          we_d    = win ? p1_we_i    : p0_we_i;
          wdata_d = win ? p1_wdata_i : p0_wdata_i;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // Faulting accesses never reach the memory enables.
        mem_addr_o  = addr_q;
        mem_re_o    = ~we_q & ~mis & ~inv;
        mem_we_o    = we_q & ~mis & ~inv;
        mem_wdata_o = wdata_q;
        rdata_d     = mem_re_o ? mem_rdata_i : 64'd0;
        err_d       = {inv, mis};
`ifdef DATAMEM_ARB_RR_EN
        last_d      = owner_q;
`endif
        state_d     = DONE;
      end
      DONE: begin
        p0_ack_o = ~owner_q;
        p1_ack_o = owner_q;
        rdata_o  = rdata_q;
        err_o    = err_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_riscv_datamem_arbiter.sv
// Directed, table-driven bench for riscv_datamem_arbiter with a behavioural memory.
`ifndef DATAMEM_WIDTH
`define DATAMEM_WIDTH 10
`endif

module tb_riscv_datamem_arbiter;
  localparam int IDX_W = `DATAMEM_WIDTH;
  localparam logic [63:0] TOP = 64'd1 << (IDX_W + 3);

  logic        clk;
  logic        rst;
  logic        p0_req_i, p0_we_i, p1_req_i, p1_we_i;
  logic [63:0] p0_addr_i, p0_wdata_i, p1_addr_i, p1_wdata_i;
  logic        p0_ack_o, p1_ack_o;
  logic [63:0] rdata_o;
  logic [1:0]  err_o;
  logic [63:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        mem_re_o, mem_we_o;
  logic [1:0]  dbg_state_o;

  logic [63:0] mem [2**IDX_W];
  int          n_checks;
  int          n_fail;
  logic [0:0]  exp_q[$];

  typedef struct {
    logic        port;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic [1:0]  exp_err;
  } vec_t;

  vec_t vecs[11];

  riscv_datamem_arbiter #(.IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst),
    .p0_req_i(p0_req_i), .p0_we_i(p0_we_i), .p0_addr_i(p0_addr_i), .p0_wdata_i(p0_wdata_i),
    .p1_req_i(p1_req_i), .p1_we_i(p1_we_i), .p1_addr_i(p1_addr_i), .p1_wdata_i(p1_wdata_i),
    .p0_ack_o(p0_ack_o), .p1_ack_o(p1_ack_o), .rdata_o(rdata_o), .err_o(err_o),
    .mem_addr_o(mem_addr_o), .mem_re_o(mem_re_o), .mem_we_o(mem_we_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .dbg_state_o(dbg_state_o)
  );

  // Clock / reset / memory model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata_i = mem[mem_addr_o[IDX_W+2:3]];

  always @(posedge clk) begin
    if (mem_we_o) mem[mem_addr_o[IDX_W+2:3]] = mem_wdata_o;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_port(input logic port, input logic req, input logic we,
                            input logic [63:0] addr, input logic [63:0] wdata);
    if (port == 1'b0) begin
      p0_req_i = req; p0_we_i = we; p0_addr_i = addr; p0_wdata_i = wdata;
    end else begin
      p1_req_i = req; p1_we_i = we; p1_addr_i = addr; p1_wdata_i = wdata;
    end
  endtask

  // Called at a negedge with the DUT idle; walks one fixed-latency transaction.
  task automatic run_txn(input vec_t v);
    logic ok;
    ok = (v.exp_err == 2'b00);
    drive_port(v.port, 1'b1, v.we, v.addr, v.wdata);
    @(negedge clk);
    chk("access_state", 64'(dbg_state_o), 64'd1);
    chk("access_addr", mem_addr_o, v.addr);
    chk("access_re", 64'(mem_re_o), 64'(!v.we && ok));
    chk("access_we", 64'(mem_we_o), 64'(v.we && ok));
    chk("access_wdata", mem_wdata_o, v.wdata);
    chk("access_acks", 64'({p1_ack_o, p0_ack_o}), 64'd0);
    @(negedge clk);
    chk("done_acks", 64'({p1_ack_o, p0_ack_o}), v.port ? 64'd2 : 64'd1);
    chk("done_rdata", rdata_o, v.exp_rdata);
    chk("done_err", 64'(err_o), 64'(v.exp_err));
    chk("done_mem_en", 64'({mem_we_o, mem_re_o}), 64'd0);
    drive_port(v.port, 1'b0, 1'b0, 64'd0, 64'd0);
    @(negedge clk);
    chk("idle_state", 64'(dbg_state_o), 64'd0);
    chk("idle_acks", 64'({p1_ack_o, p0_ack_o}), 64'd0);
  endtask

  initial begin
    int rem0, rem1;
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 2**IDX_W; i++) mem[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
    mem[1] = 64'hDEADBEEF_00000001;
    mem[3] = 64'h3333;

    vecs[0]  = '{1'b0, 1'b0, 64'd8,      64'd0,    64'hDEADBEEF_00000001, 2'b00};
    vecs[1]  = '{1'b1, 1'b1, 64'd16,     64'h1234, 64'd0,                 2'b00};
    vecs[2]  = '{1'b1, 1'b0, 64'd16,     64'd0,    64'h1234,              2'b00};
    vecs[3]  = '{1'b0, 1'b1, 64'd12,     64'hFF,   64'd0,                 2'b01};
    vecs[4]  = '{1'b0, 1'b0, 64'd8,      64'd0,    64'hDEADBEEF_00000001, 2'b00};
    vecs[5]  = '{1'b1, 1'b0, TOP,        64'd0,    64'd0,                 2'b10};
    vecs[6]  = '{1'b0, 1'b1, TOP + 4,    64'h77,   64'd0,                 2'b11};
    vecs[7]  = '{1'b0, 1'b0, 64'd5,      64'd0,    64'd0,                 2'b01};
    vecs[8]  = '{1'b1, 1'b1, TOP - 8,    64'hCAFE, 64'd0,                 2'b00};
    vecs[9]  = '{1'b0, 1'b0, TOP - 8,    64'd0,    64'hCAFE,              2'b00};
    vecs[10] = '{1'b1, 1'b0, 64'd24,     64'd0,    64'h3333,              2'b00};

    rst = 1'b1;
    drive_port(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
    drive_port(1'b1, 1'b0, 1'b0, 64'd0, 64'd0);
    repeat (2) @(negedge clk);
    chk("rst_state", 64'(dbg_state_o), 64'd0);
    chk("rst_acks", 64'({p1_ack_o, p0_ack_o}), 64'd0);
    chk("rst_rdata", rdata_o, 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_mem_addr", mem_addr_o, 64'd0);
    chk("rst_mem_wdata", mem_wdata_o, 64'd0);
    chk("rst_mem_en", 64'({mem_we_o, mem_re_o}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 11; i++) run_txn(vecs[i]);
    chk("mem_word2_store", mem[2], 64'h1234);

    // Both ports load, each holding until it has seen 4 acks; last owner was port 1.
`ifdef DATAMEM_ARB_RR_EN
    for (int i = 0; i < 8; i++) exp_q.push_back(1'(i % 2));
`else
    for (int i = 0; i < 8; i++) exp_q.push_back(1'(i / 4));
`endif
    rem0 = 4;
    rem1 = 4;
    drive_port(1'b0, 1'b1, 1'b0, 64'd8, 64'd0);
    drive_port(1'b1, 1'b1, 1'b0, 64'd16, 64'd0);
    for (int c = 0; c < 60 && (rem0 > 0 || rem1 > 0); c++) begin
      @(negedge clk);
      chk("ack_exclusive", 64'(p0_ack_o & p1_ack_o), 64'd0);
      if (p0_ack_o || p1_ack_o) begin
        if (exp_q.size() == 0) begin
          chk("grant_extra", 64'd1, 64'd0);
        end else begin
          chk("grant_order", 64'(p1_ack_o), 64'(exp_q.pop_front()));
        end
        chk("grant_rdata", rdata_o, p1_ack_o ? 64'h1234 : 64'hDEADBEEF_00000001);
        if (p0_ack_o) begin
          rem0--;
          if (rem0 == 0) drive_port(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        end else begin
          rem1--;
          if (rem1 == 0) drive_port(1'b1, 1'b0, 1'b0, 64'd0, 64'd0);
        end
      end
    end
    chk("grant_all_served", 64'(exp_q.size()), 64'd0);
    drive_port(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
    drive_port(1'b1, 1'b0, 1'b0, 64'd0, 64'd0);
    repeat (3) @(negedge clk);
    chk("grant_idle", 64'(dbg_state_o), 64'd0);

    // Reset during ACCESS of a store to word 3; the held request retries afterwards.
    drive_port(1'b0, 1'b1, 1'b1, 64'd24, 64'hBAD);
    @(negedge clk);
    chk("rst_mid_we_before", 64'(mem_we_o), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_we_dropped", 64'(mem_we_o), 64'd0);
    chk("rst_mid_state", 64'(dbg_state_o), 64'd0);
    @(negedge clk);
    chk("rst_mid_no_ack", 64'({p1_ack_o, p0_ack_o}), 64'd0);
    chk("rst_mid_mem3", mem[3], 64'h3333);
    rst = 1'b0;
    @(negedge clk);
    chk("retry_access_we", 64'(mem_we_o), 64'd1);
    chk("retry_access_addr", mem_addr_o, 64'd24);
    @(negedge clk);
    chk("retry_ack", 64'({p1_ack_o, p0_ack_o}), 64'd1);
    chk("retry_err", 64'(err_o), 64'd0);
    chk("retry_mem3", mem[3], 64'hBAD);
    drive_port(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
    @(negedge clk);
    chk("retry_idle", 64'(dbg_state_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
